// File: rtl/ac_pkg.sv
// Shared definitions for the AXI-Stream output packer: pixel format and the
// lane / byte-enable width helpers used to size the packed output word.
package ac_pkg;

    // RGB888: three bytes per pixel
    localparam int BYTES_PER_PIX = 3;

    // Bits carried by one lane (one input packet)
    function automatic int lane_bits(input int pix_width, input int pkt_pix);
        return pix_width * pkt_pix;
    endfunction

    // Byte enables belonging to one lane
    function automatic int lane_keep_bits(input int pix_width, input int pkt_pix);
        return lane_bits(pix_width, pkt_pix) / 8;
    endfunction

    // Index width for a lane counter; never narrower than one bit
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ac_outpack_fifo.sv
// Generic synchronous FIFO. Extra pointer MSB distinguishes full from empty.
// not_full is a flop computed from the next occupancy so that a pop while
// full shows up as free space one cycle later and never combinationally.
module ac_outpack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_d;
    logic             not_full_q, not_full_d;
    logic             push_ok_s, pop_ok_s;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next pointers and next-cycle space availability
    always_comb begin
        push_ok_s = push & not_full_q;
        pop_ok_s  = pop & (wr_ptr_q != rd_ptr_q);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d    = wr_ptr_d - rd_ptr_d;
        not_full_d = (count_d != FULL_CNT);
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            not_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            not_full_q <= not_full_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata    = mem_q[rd_ptr_q[AW-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign not_full = not_full_q;

endmodule

// File: rtl/ac_outpack.sv
// Packs the UPSP packet stream into N_PARALLEL-lane AXI-Stream words.
// Lanes fill in arrival order from the LSBs; a row end flushes a partial
// word with zeroed, byte-disabled upper lanes. tlast marks row ends, tuser
// the first word of each frame, and frame_done follows the final tlast.
module ac_outpack
    import ac_pkg::*;
#(
    parameter int PIX_WIDTH      = BYTES_PER_PIX * 8,
    parameter int PKT_PIX        = 1,
    parameter int N_PARALLEL     = 2,
    parameter int DST_IMG_WIDTH  = 4096,
    parameter int DST_IMG_HEIGHT = 2160,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PKT_PIX*PIX_WIDTH-1:0]          in_data,
    output logic [N_PARALLEL*PKT_PIX*PIX_WIDTH-1:0] m_tdata,
    output logic [N_PARALLEL*PKT_PIX*PIX_WIDTH/8-1:0] m_tkeep,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic                                  m_tlast,
    output logic                                  m_tuser,
    output logic                                  frame_done
);

    localparam int LANE_W  = lane_bits(PIX_WIDTH, PKT_PIX);
    localparam int LANE_KW = lane_keep_bits(PIX_WIDTH, PKT_PIX);
    localparam int WORD_W  = LANE_W * N_PARALLEL;
    localparam int KEEP_W  = LANE_KW * N_PARALLEL;
    localparam int FIFO_W  = WORD_W + KEEP_W + 2;
    localparam int LIDX_W  = idx_bits(N_PARALLEL);
    localparam int COL_W   = $clog2(DST_IMG_WIDTH + 1);
    localparam int ROW_W   = $clog2(DST_IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0]  COL_STEP       = COL_W'(PKT_PIX);
    localparam logic [COL_W-1:0]  COL_END        = COL_W'(DST_IMG_WIDTH);
    localparam logic [COL_W-1:0]  COL_FIRST_WORD = COL_W'(N_PARALLEL * PKT_PIX);
    localparam logic [ROW_W-1:0]  ROW_LAST       = ROW_W'(DST_IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE        = ROW_W'(1);
    localparam logic [LIDX_W-1:0] LANE_LAST      = LIDX_W'(N_PARALLEL - 1);
    localparam logic [LIDX_W-1:0] LANE_ONE       = LIDX_W'(1);

    logic [WORD_W-1:0] pack_q, pack_d;
    logic [LIDX_W-1:0] lane_q, lane_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic              frame_done_q, frame_done_d;

    logic              accept_s, row_end_s, word_push_s, user_s, pop_s;
    logic [WORD_W-1:0] word_s;
    logic [KEEP_W-1:0] keep_s;
    logic [FIFO_W-1:0] fifo_wdata_s, fifo_rdata_s;
    logic              fifo_empty_s, fifo_not_full_s;

    assign in_ready = fifo_not_full_s;
    assign accept_s = in_valid & fifo_not_full_s;

    // Merge the incoming packet into its lane and build the byte enables
    always_comb begin
        word_s = pack_q;
        keep_s = '0;
        for (int i = 0; i < N_PARALLEL; i++) begin
            if (LIDX_W'(i) == lane_q) begin
                word_s[i*LANE_W +: LANE_W] = in_data;
            end else begin
                word_s[i*LANE_W +: LANE_W] = pack_q[i*LANE_W +: LANE_W];
            end
            if (LIDX_W'(i) <= lane_q) begin
                keep_s[i*LANE_KW +: LANE_KW] = '1;
            end else begin
                keep_s[i*LANE_KW +: LANE_KW] = '0;
            end
        end
        row_end_s    = ((col_q + COL_STEP) == COL_END);
        word_push_s  = accept_s & ((lane_q == LANE_LAST) | row_end_s);
        user_s       = (row_q == '0) & (col_q < COL_FIRST_WORD);
        fifo_wdata_s = {word_s, keep_s, row_end_s, user_s};
    end

    // Lane index, pack register and pixel position advance on each accept
    always_comb begin
        pack_d = pack_q;
        lane_d = lane_q;
        col_d  = col_q;
        row_d  = row_q;
        if (accept_s) begin
            if (word_push_s) begin
                pack_d = '0;
                lane_d = '0;
            end else begin
                pack_d = word_s;
                lane_d = lane_q + LANE_ONE;
            end
            if (row_end_s) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_STEP;
                row_d = row_q;
            end
        end else begin
            pack_d = pack_q;
            lane_d = lane_q;
        end
    end

    // Output side: present the FIFO head, zero while nothing is valid
    always_comb begin
        m_tvalid = ~fifo_empty_s;
        pop_s    = ~fifo_empty_s & m_tready;
        if (fifo_empty_s) begin
            {m_tdata, m_tkeep, m_tlast, m_tuser} = '0;
        end else begin
            {m_tdata, m_tkeep, m_tlast, m_tuser} = fifo_rdata_s;
        end
    end

    // Track rows leaving the block to flag the frame's final handshake
    always_comb begin
        out_row_d    = out_row_q;
        frame_done_d = 1'b0;
        if (pop_s && m_tlast) begin
            if (out_row_q == ROW_LAST) begin
                out_row_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                out_row_d    = out_row_q + ROW_ONE;
                frame_done_d = 1'b0;
            end
        end else begin
            out_row_d    = out_row_q;
            frame_done_d = 1'b0;
        end
    end

    // State registers; reset drops any partially packed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q       <= '0;
            lane_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pack_q       <= pack_d;
            lane_q       <= lane_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

    ac_outpack_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (word_push_s),
        .wdata    (fifo_wdata_s),
        .pop      (pop_s),
        .rdata    (fifo_rdata_s),
        .empty    (fifo_empty_s),
        .not_full (fifo_not_full_s)
    );

endmodule

// File: tb/tb_ac_outpack.sv
// Scoreboard bench for ac_outpack. Instance A: 1 pixel/packet, 4 lanes,
// 6x2 image. Instance B: 4 pixels/packet, 2 lanes, 12x2 image.
module tb_ac_outpack;

    localparam int WA = 96 + 12 + 2;
    localparam int WB = 192 + 24 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         in_valid_a, in_ready_a;
    logic [23:0]  in_data_a;
    logic [95:0]  m_tdata_a;
    logic [11:0]  m_tkeep_a;
    logic         m_tvalid_a, m_tready_a, m_tlast_a, m_tuser_a, frame_done_a;

    logic         in_valid_b, in_ready_b;
    logic [95:0]  in_data_b;
    logic [191:0] m_tdata_b;
    logic [23:0]  m_tkeep_b;
    logic         m_tvalid_b, m_tready_b, m_tlast_b, m_tuser_b, frame_done_b;

    ac_outpack #(.PIX_WIDTH(24), .PKT_PIX(1), .N_PARALLEL(4), .DST_IMG_WIDTH(6),
                 .DST_IMG_HEIGHT(2), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .m_tdata(m_tdata_a), .m_tkeep(m_tkeep_a),
        .m_tvalid(m_tvalid_a), .m_tready(m_tready_a), .m_tlast(m_tlast_a),
        .m_tuser(m_tuser_a), .frame_done(frame_done_a));

    ac_outpack #(.PIX_WIDTH(24), .PKT_PIX(4), .N_PARALLEL(2), .DST_IMG_WIDTH(12),
                 .DST_IMG_HEIGHT(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .m_tdata(m_tdata_b), .m_tkeep(m_tkeep_b),
        .m_tvalid(m_tvalid_b), .m_tready(m_tready_b), .m_tlast(m_tlast_b),
        .m_tuser(m_tuser_b), .frame_done(frame_done_b));

    int n_tests = 0;
    int n_fail  = 0;

    logic [WA-1:0] exp_a[$];
    bit            exp_fe_a[$];
    logic [WB-1:0] exp_b[$];
    bit            exp_fe_b[$];

    bit fd_exp_a = 1'b0, fd_exp_b = 1'b0;
    int fd_cnt_a = 0, fd_cnt_b = 0, user_cnt_a = 0;
    bit rand_rdy = 1'b0;

    // Reference packing state for instance A
    int           ma_lane = 0, ma_col = 0, ma_row = 0;
    logic [95:0]  ma_data = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        ma_lane = 0; ma_col = 0; ma_row = 0; ma_data = '0;
    endtask

    // Row-oriented packing reference: 4 pixels per word, flush at column 6
    task automatic model_a(input logic [23:0] pix);
        logic [11:0] keep;
        logic        last, user;
        ma_data[ma_lane*24 +: 24] = pix;
        ma_lane++;
        ma_col++;
        if (ma_lane == 4 || ma_col == 6) begin
            for (int i = 0; i < 12; i++) keep[i] = (i < ma_lane * 3);
            last = (ma_col == 6);
            user = (ma_row == 0) && (ma_col == ma_lane);
            exp_a.push_back({ma_data, keep, last, user});
            exp_fe_a.push_back(last && (ma_row == 1));
            ma_data = '0;
            ma_lane = 0;
            if (last) begin
                ma_col = 0;
                ma_row = (ma_row == 1) ? 0 : ma_row + 1;
            end
        end
    endtask

    task automatic send_a(input logic [23:0] pix, input bit gaps);
        int t;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid_a = 1'b0;
            @(posedge clk); #1;
        end
        in_valid_a = 1'b1;
        in_data_a  = pix;
        t = 0;
        @(negedge clk);
        while (!in_ready_a && t < 1000) begin @(negedge clk); t++; end
        if (in_ready_a) begin
            @(posedge clk); #1;
            model_a(pix);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL send_a: in_ready actual 0 required 1 within 1000 cycles");
            in_valid_a = 1'b0;
        end
    endtask

    task automatic send_b(input logic [95:0] pkt);
        int t;
        in_valid_b = 1'b1;
        in_data_b  = pkt;
        t = 0;
        @(negedge clk);
        while (!in_ready_b && t < 1000) begin @(negedge clk); t++; end
        if (in_ready_b) begin
            @(posedge clk); #1;
        end else begin
            n_tests++; n_fail++;
            $display("FAIL send_b: in_ready actual 0 required 1 within 1000 cycles");
            in_valid_b = 1'b0;
        end
    endtask

    task automatic drain(input bit which_b);
        int t = 0;
        while (((which_b ? exp_b.size() : exp_a.size()) != 0) && t < 3000) begin
            @(posedge clk); t++;
        end
        if ((which_b ? exp_b.size() : exp_a.size()) != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: words outstanding actual %0d required 0",
                     which_b ? exp_b.size() : exp_a.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] pkt_b(input int k);
        logic [95:0] v;
        for (int j = 0; j < 4; j++) v[j*24 +: 24] = 24'hE00000 | 24'(k * 16 + j);
        return v;
    endfunction

    // Random output backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_rdy) m_tready_a = ($urandom_range(0, 1) == 1);
    end

    // Scoreboard monitor for instance A
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done_a || fd_exp_a) check("frame_done_a", 256'(frame_done_a), 256'(fd_exp_a));
            if (frame_done_a) fd_cnt_a++;
            fd_exp_a = 1'b0;
            if (m_tvalid_a && m_tready_a) begin
                if (m_tuser_a) user_cnt_a++;
                if (exp_a.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL word_a: unexpected word actual %0h required none", m_tdata_a);
                end else begin
                    check("word_a", 256'({m_tdata_a, m_tkeep_a, m_tlast_a, m_tuser_a}),
                          256'(exp_a.pop_front()));
                    fd_exp_a = exp_fe_a.pop_front();
                end
            end
        end
    end

    // Scoreboard monitor for instance B
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done_b || fd_exp_b) check("frame_done_b", 256'(frame_done_b), 256'(fd_exp_b));
            if (frame_done_b) fd_cnt_b++;
            fd_exp_b = 1'b0;
            if (m_tvalid_b && m_tready_b) begin
                if (exp_b.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL word_b: unexpected word actual %0h required none", m_tdata_b);
                end else begin
                    check("word_b", 256'({m_tdata_b, m_tkeep_b, m_tlast_b, m_tuser_b}),
                          256'(exp_b.pop_front()));
                    fd_exp_b = exp_fe_b.pop_front();
                end
            end
        end
    end

    initial begin
        int fd0, us0;
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; m_tready_a = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; m_tready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_in_ready_a", 256'(in_ready_a), 256'(0));
        check("rst_outs_a", 256'({m_tvalid_a, m_tdata_a, m_tkeep_a, m_tlast_a, m_tuser_a, frame_done_a}), 256'(0));
        check("rst_outs_b", 256'({in_ready_b, m_tvalid_b, m_tdata_b, m_tkeep_b, m_tlast_b, m_tuser_b, frame_done_b}), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", 256'(in_ready_a), 256'(0));
        @(negedge clk);
        check("in_ready_after_release_a", 256'(in_ready_a), 256'(1));
        check("in_ready_after_release_b", 256'(in_ready_b), 256'(1));
        @(posedge clk); #1;

        // One 6x2 frame, continuous input, sink always ready
        m_tready_a = 1'b1;
        fd0 = fd_cnt_a; us0 = user_cnt_a;
        for (int p = 0; p < 12; p++) begin
            send_a(24'hA00000 + 24'(p), 1'b0);
            if (p == 2) check("latency_not_yet", 256'(m_tvalid_a), 256'(0));
            if (p == 3) check("latency_one", 256'(m_tvalid_a), 256'(1));
        end
        in_valid_a = 1'b0;
        drain(1'b0);
        check("frame_done_count_1", 256'(fd_cnt_a - fd0), 256'(1));
        check("tuser_count_1", 256'(user_cnt_a - us0), 256'(1));

        // Backpressure: 48 pixels fill all 16 FIFO words
        m_tready_a = 1'b0;
        fd0 = fd_cnt_a; us0 = user_cnt_a;
        for (int p = 0; p < 48; p++) send_a(24'hB00000 + 24'(p), 1'b0);
        in_valid_a = 1'b0;
        @(negedge clk);
        check("full_in_ready", 256'(in_ready_a), 256'(0));
        check("full_tvalid", 256'(m_tvalid_a), 256'(1));
        @(posedge clk); #1;
        m_tready_a = 1'b1;
        @(posedge clk); #1;
        m_tready_a = 1'b0;
        @(negedge clk);
        check("pop_frees_slot", 256'(in_ready_a), 256'(1));
        @(posedge clk); #1;
        m_tready_a = 1'b1;
        drain(1'b0);
        check("frame_done_count_4", 256'(fd_cnt_a - fd0), 256'(4));
        check("tuser_count_4", 256'(user_cnt_a - us0), 256'(4));

        // Random valid/ready over 3 frames
        fd0 = fd_cnt_a; us0 = user_cnt_a;
        rand_rdy = 1'b1;
        for (int p = 0; p < 36; p++) send_a(24'h300000 + 24'(p), 1'b1);
        in_valid_a = 1'b0;
        drain(1'b0);
        rand_rdy = 1'b0;
        m_tready_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("frame_done_count_3", 256'(fd_cnt_a - fd0), 256'(3));
        check("tuser_count_3", 256'(user_cnt_a - us0), 256'(3));

        // Reset after 5 pixels of row 1 with words still queued
        m_tready_a = 1'b0;
        for (int p = 0; p < 11; p++) send_a(24'hC00000 + 24'(p), 1'b0);
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        exp_a.delete(); exp_fe_a.delete(); model_reset(); fd_exp_a = 1'b0;
        #1;
        check("midrst_in_ready", 256'(in_ready_a), 256'(0));
        check("midrst_outs", 256'({m_tvalid_a, m_tdata_a, m_tkeep_a, m_tlast_a, m_tuser_a, frame_done_a}), 256'(0));
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_tready_a = 1'b1;
        fd0 = fd_cnt_a; us0 = user_cnt_a;
        for (int p = 0; p < 12; p++) send_a(24'hD00000 + 24'(p), 1'b0);
        in_valid_a = 1'b0;
        drain(1'b0);
        check("post_rst_frame_done", 256'(fd_cnt_a - fd0), 256'(1));
        check("post_rst_tuser", 256'(user_cnt_a - us0), 256'(1));

        // Instance B: 3 packets per row, second word half-filled
        exp_b.push_back({pkt_b(1), pkt_b(0), 24'hFFFFFF, 1'b0, 1'b1}); exp_fe_b.push_back(1'b0);
        exp_b.push_back({96'h0, pkt_b(2), 24'h000FFF, 1'b1, 1'b0});    exp_fe_b.push_back(1'b0);
        exp_b.push_back({pkt_b(4), pkt_b(3), 24'hFFFFFF, 1'b0, 1'b0}); exp_fe_b.push_back(1'b0);
        exp_b.push_back({96'h0, pkt_b(5), 24'h000FFF, 1'b1, 1'b0});    exp_fe_b.push_back(1'b1);
        fd0 = fd_cnt_b;
        for (int k = 0; k < 6; k++) send_b(pkt_b(k));
        in_valid_b = 1'b0;
        drain(1'b1);
        check("frame_done_b_count", 256'(fd_cnt_b - fd0), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
